// File: rtl/jtag_tap_controller_if.sv
// ---------------------------------------------------------------------------
// jtag_tap_controller_if
//   Groups the JTAG pin signals and the boundary-scan chain control signals
//   of the TAP controller into one bundle.
//
//   Pin side:
//     TMS      host -> TAP   mode select, sampled on TCK rising edge
//     TDI      host -> TAP   serial data in (also feeds the chain TDI)
//     TDO      TAP  -> host  serial data out, launched on TCK falling edge
//     TDO_en   TAP  -> host  pad output enable, high while shifting IR or DR
//   Chain side:
//     bsr_tdo  chain -> TAP  serial output of the boundary scan chain
//     ShiftDR  TAP -> chain  1 = shift path, 0 = capture path
//     ClockDR  TAP -> chain  capture/shift enable
//     UpdateDR TAP -> chain  update-latch enable
//     Mode     TAP -> chain  1 = update latches drive the pins (EXTEST)
//
//   master: the environment (JTAG host plus chain model)
//   slave:  the TAP controller
// ---------------------------------------------------------------------------
interface jtag_tap_controller_if;
    logic TMS;
    logic TDI;
    logic TDO;
    logic TDO_en;
    logic bsr_tdo;
    logic ShiftDR;
    logic ClockDR;
    logic UpdateDR;
    logic Mode;

    modport master (
        output TMS,
        output TDI,
        output bsr_tdo,
        input  TDO,
        input  TDO_en,
        input  ShiftDR,
        input  ClockDR,
        input  UpdateDR,
        input  Mode
    );

    modport slave (
        input  TMS,
        input  TDI,
        input  bsr_tdo,
        output TDO,
        output TDO_en,
        output ShiftDR,
        output ClockDR,
        output UpdateDR,
        output Mode
    );
endinterface

// File: rtl/jtag_tap_controller.sv
// ---------------------------------------------------------------------------
// jtag_tap_controller
//   IEEE 1149.1-style TAP: 16-state TMS-driven FSM, instruction register,
//   BYPASS and IDCODE data registers. Drives the boundary scan chain controls
//   and muxes the selected register onto TDO.
//
// Parameters
//   IR_W    instruction register width (>= 2)
//   IDCODE  device ID loaded in Capture-DR under IDCODE (bit 0 must be 1)
//
// Ports
//   TCK        the single clock; state on rising edge, TDO/TDO_en on falling
//   TRST_N     asynchronous active-low reset
//   jtag       pin and chain signals (slave modport)
//   tap_state  current FSM state code (debug)
//   ir_value   current (updated) instruction
// ---------------------------------------------------------------------------
module jtag_tap_controller #(
    parameter int unsigned IR_W   = 4,
    parameter logic [31:0] IDCODE = 32'h1000_0001
) (
    input  logic                    TCK,
    input  logic                    TRST_N,
    jtag_tap_controller_if.slave    jtag,
    output logic [3:0]              tap_state,
    output logic [IR_W-1:0]         ir_value
);

    // State codes follow the 1149.1 reference encoding so tap_state is
    // directly comparable with standard debugger views.
    typedef enum logic [3:0] {
        StEx2Dr   = 4'h0,
        StEx1Dr   = 4'h1,
        StShDr    = 4'h2,
        StPauseDr = 4'h3,
        StSelIr   = 4'h4,
        StUpdDr   = 4'h5,
        StCapDr   = 4'h6,
        StSelDr   = 4'h7,
        StEx2Ir   = 4'h8,
        StEx1Ir   = 4'h9,
        StShIr    = 4'hA,
        StPauseIr = 4'hB,
        StRti     = 4'hC,
        StUpdIr   = 4'hD,
        StCapIr   = 4'hE,
        StTlr     = 4'hF
    } tap_state_e;

    localparam logic [IR_W-1:0] IrExtest  = '0;
    localparam logic [IR_W-1:0] IrSample  = IR_W'(1);
    localparam logic [IR_W-1:0] IrIdcode  = IR_W'(2);
    localparam logic [IR_W-1:0] IrCapture = IR_W'(1);

    tap_state_e          state_q, state_d;
    logic [IR_W-1:0]     ir_sr_q, ir_sr_d;
    logic [IR_W-1:0]     ir_value_q, ir_value_d;
    logic [31:0]         idreg_q, idreg_d;
    logic                bypass_q, bypass_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;

    logic                bsr_sel;
    logic                id_sel;
    logic                byp_sel;
    logic                dr_lsb;

    // Unlisted codes fall through to BYPASS.
    assign bsr_sel = (ir_value_q == IrExtest) || (ir_value_q == IrSample);
    assign id_sel  = (ir_value_q == IrIdcode);
    assign byp_sel = !bsr_sel && !id_sel;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state_q <= StTlr;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTlr:     state_d = jtag.TMS ? StTlr     : StRti;
            StRti:     state_d = jtag.TMS ? StSelDr   : StRti;
            StSelDr:   state_d = jtag.TMS ? StSelIr   : StCapDr;
            StCapDr:   state_d = jtag.TMS ? StEx1Dr   : StShDr;
            StShDr:    state_d = jtag.TMS ? StEx1Dr   : StShDr;
            StEx1Dr:   state_d = jtag.TMS ? StUpdDr   : StPauseDr;
            StPauseDr: state_d = jtag.TMS ? StEx2Dr   : StPauseDr;
            StEx2Dr:   state_d = jtag.TMS ? StUpdDr   : StShDr;
            StUpdDr:   state_d = jtag.TMS ? StSelDr   : StRti;
            StSelIr:   state_d = jtag.TMS ? StTlr     : StCapIr;
            StCapIr:   state_d = jtag.TMS ? StEx1Ir   : StShIr;
            StShIr:    state_d = jtag.TMS ? StEx1Ir   : StShIr;
            StEx1Ir:   state_d = jtag.TMS ? StUpdIr   : StPauseIr;
            StPauseIr: state_d = jtag.TMS ? StEx2Ir   : StPauseIr;
            StEx2Ir:   state_d = jtag.TMS ? StUpdIr   : StShIr;
            StUpdIr:   state_d = jtag.TMS ? StSelDr   : StRti;
            default:   state_d = StTlr;
        endcase
    end

    // ------------------------------------------------------------------
    // IR and DR datapath: every action happens on the edge leaving the
    // state that names it; pause/exit states leave everything untouched.
    // ------------------------------------------------------------------
    always_comb begin
        ir_sr_d    = ir_sr_q;
        ir_value_d = ir_value_q;
        idreg_d    = idreg_q;
        bypass_d   = bypass_q;
        case (state_q)
            StTlr:   ir_value_d = IrIdcode;
            StCapIr: ir_sr_d    = IrCapture;
            StShIr:  ir_sr_d    = {jtag.TDI, ir_sr_q[IR_W-1:1]};
            StUpdIr: ir_value_d = ir_sr_q;
            StCapDr: begin
                if (id_sel) begin
                    idreg_d = IDCODE;
                end
                if (byp_sel) begin
                    bypass_d = 1'b0;
                end
            end
            StShDr: begin
                if (id_sel) begin
                    idreg_d = {jtag.TDI, idreg_q[31:1]};
                end
                if (byp_sel) begin
                    bypass_d = jtag.TDI;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_sr_q    <= '0;
            ir_value_q <= IrIdcode;
            idreg_q    <= '0;
            bypass_q   <= 1'b0;
        end else begin
            ir_sr_q    <= ir_sr_d;
            ir_value_q <= ir_value_d;
            idreg_q    <= idreg_d;
            bypass_q   <= bypass_d;
        end
    end

    // ------------------------------------------------------------------
    // TDO launch on the falling edge so the host samples a stable bit on
    // the next rising edge.
    // ------------------------------------------------------------------
    always_comb begin
        dr_lsb = bypass_q;
        if (bsr_sel) begin
            dr_lsb = jtag.bsr_tdo;
        end else if (id_sel) begin
            dr_lsb = idreg_q[0];
        end
    end

    always_comb begin
        tdo_d    = 1'b0;
        tdo_en_d = 1'b0;
        if (state_q == StShIr) begin
            tdo_d    = ir_sr_q[0];
            tdo_en_d = 1'b1;
        end else if (state_q == StShDr) begin
            tdo_d    = dr_lsb;
            tdo_en_d = 1'b1;
        end
    end

    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: chain controls are Moore decodes of the state register.
    // ------------------------------------------------------------------
    assign jtag.ShiftDR  = (state_q == StShDr);
    assign jtag.ClockDR  = bsr_sel && ((state_q == StCapDr) || (state_q == StShDr));
    assign jtag.UpdateDR = bsr_sel && (state_q == StUpdDr);
    assign jtag.Mode     = (ir_value_q == IrExtest);
    assign jtag.TDO      = tdo_q;
    assign jtag.TDO_en   = tdo_en_q;

    assign tap_state = state_q;
    assign ir_value  = ir_value_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// ---------------------------------------------------------------------------
// tb_jtag_tap_controller
//   Drives random and directed TMS/TDI/bsr_tdo sequences into the TAP. A
//   reference model (transition table plus bit queues for IR/DR contents)
//   pushes the expected chain controls per cycle and the expected TDO bits
//   into queues; two monitors pop and compare on the rising/falling edges.
// ---------------------------------------------------------------------------
module tb_jtag_tap_controller;

    localparam int unsigned IR_W = 4;
    localparam logic [31:0] ID   = 32'h1000_0001;

    localparam logic [3:0] CTlr  = 4'hF;
    localparam logic [3:0] CCapDr = 4'h6;
    localparam logic [3:0] CShDr  = 4'h2;
    localparam logic [3:0] CUpdDr = 4'h5;
    localparam logic [3:0] CCapIr = 4'hE;
    localparam logic [3:0] CShIr  = 4'hA;
    localparam logic [3:0] CUpdIr = 4'hD;

    // Next state indexed by state code, for TMS=0 and TMS=1.
    logic [3:0] to0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                             4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] to1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                             4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    typedef struct packed {
        logic [3:0]      st;
        logic            sh;
        logic            ck;
        logic            up;
        logic            md;
        logic [IR_W-1:0] ir;
    } exp_t;

    logic            TCK = 1'b0;
    logic            TRST_N = 1'b1;
    logic [3:0]      tap_state;
    logic [IR_W-1:0] ir_value;

    jtag_tap_controller_if jif ();

    jtag_tap_controller #(
        .IR_W   (IR_W),
        .IDCODE (ID)
    ) dut (
        .TCK       (TCK),
        .TRST_N    (TRST_N),
        .jtag      (jif),
        .tap_state (tap_state),
        .ir_value  (ir_value)
    );

    always #5 TCK = ~TCK;

    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    bit   tdo_q[$];

    // Reference model state
    logic [3:0]      m_st;
    logic [IR_W-1:0] m_ir;
    bit              ir_bits[$];
    bit              dr_bits[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic bit rtms(input int unsigned pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    function automatic bit is_chain(input logic [IR_W-1:0] ir);
        return (ir == 0) || (ir == 1);
    endfunction

    task automatic push_exp();
        exp_t e;
        bit   chain;
        chain = is_chain(m_ir);
        e.st = m_st;
        e.sh = (m_st == CShDr);
        e.ck = chain && ((m_st == CCapDr) || (m_st == CShDr));
        e.up = chain && (m_st == CUpdDr);
        e.md = (m_ir == 0);
        e.ir = m_ir;
        exp_q.push_back(e);
    endtask

    // Effect of one rising edge given the inputs of this cycle.
    task automatic model_step(input bit tms, input bit tdi, input bit bsr);
        logic [3:0] cur;
        cur = m_st;
        if (cur == CCapIr) begin
            ir_bits.delete();
            for (int i = 0; i < IR_W; i++) ir_bits.push_back(i == 0);
        end else if (cur == CShIr) begin
            void'(ir_bits.pop_front());
            ir_bits.push_back(tdi);
        end else if (cur == CUpdIr) begin
            for (int i = 0; i < IR_W; i++) m_ir[i] = ir_bits[i];
        end else if (cur == CTlr) begin
            m_ir = IR_W'(2);
        end else if (cur == CCapDr && !is_chain(m_ir)) begin
            dr_bits.delete();
            if (m_ir == 2) begin
                for (int i = 0; i < 32; i++) dr_bits.push_back(ID[i]);
            end else begin
                dr_bits.push_back(1'b0);
            end
        end else if (cur == CShDr && !is_chain(m_ir)) begin
            void'(dr_bits.pop_front());
            dr_bits.push_back(tdi);
        end
        m_st = tms ? to1[cur] : to0[cur];
        push_exp();
        if (m_st == CShIr) begin
            tdo_q.push_back(ir_bits[0]);
        end else if (m_st == CShDr) begin
            if (is_chain(m_ir)) tdo_q.push_back(bsr);
            else                tdo_q.push_back(dr_bits.size() > 0 ? dr_bits[0] : 1'b0);
        end
    endtask

    task automatic tick(input bit tms, input bit tdi);
        bit bsr;
        @(negedge TCK);
        #2;
        bsr          = rbit();
        TRST_N       = 1'b1;
        jif.TMS      = tms;
        jif.TDI      = tdi;
        jif.bsr_tdo  = bsr;
        model_step(tms, tdi, bsr);
    endtask

    task automatic do_reset();
        @(negedge TCK);
        #2;
        TRST_N = 1'b0;
        #1;
        chk("rst_state", 64'(tap_state), 64'(CTlr));
        chk("rst_tdo", 64'(jif.TDO), 64'(0));
        chk("rst_tdo_en", 64'(jif.TDO_en), 64'(0));
        chk("rst_mode", 64'(jif.Mode), 64'(0));
        chk("rst_ir", 64'(ir_value), 64'(2));
        m_st = CTlr;
        m_ir = IR_W'(2);
        ir_bits.delete();
        for (int i = 0; i < IR_W; i++) ir_bits.push_back(1'b0);
        dr_bits.delete();
        tdo_q.delete();
        push_exp();
        mon_en = 1'b1;
    endtask

    task automatic goto_rti();
        repeat (5) tick(1'b1, rbit());
        tick(1'b0, rbit());
    endtask

    // Assumes RTI; ends in RTI.
    task automatic load_ir(input logic [IR_W-1:0] v);
        tick(1'b1, rbit());
        tick(1'b1, rbit());
        tick(1'b0, rbit());
        tick(1'b0, rbit());
        for (int i = 0; i < IR_W; i++) tick(i == IR_W - 1, v[i]);
        tick(1'b1, rbit());
        tick(1'b0, rbit());
    endtask

    // Assumes RTI; ends in RTI.
    task automatic scan_dr(input int n);
        tick(1'b1, rbit());
        tick(1'b0, rbit());
        tick(1'b0, rbit());
        for (int i = 0; i < n; i++) tick(i == n - 1, rbit());
        tick(1'b1, rbit());
        tick(1'b0, rbit());
    endtask

    // Rising-edge monitor: chain controls, state and instruction.
    initial begin
        exp_t e;
        forever begin
            @(posedge TCK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ctl", 64'({tap_state, jif.ShiftDR, jif.ClockDR, jif.UpdateDR, jif.Mode,
                                ir_value}), 64'(e));
            end
        end
    end

    // Falling-edge monitor: serial output.
    initial begin
        bit have;
        bit b;
        forever begin
            @(negedge TCK);
            #1;
            if (mon_en) begin
                have = (tdo_q.size() > 0);
                chk("tdo_en", 64'(jif.TDO_en), 64'(have));
                if (have) begin
                    b = tdo_q.pop_front();
                    if (jif.TDO_en) chk("tdo_bit", 64'(jif.TDO), 64'(b));
                end else begin
                    chk("tdo_idle", 64'(jif.TDO), 64'(0));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        jif.TMS     = 1'b1;
        jif.TDI     = 1'b0;
        jif.bsr_tdo = 1'b0;
        do_reset();

        // RTI, then five TMS=1 back to TLR.
        tick(1'b0, 1'b0);
        repeat (5) tick(1'b1, rbit());

        // IDCODE read straight after reset.
        do_reset();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) tick(i == 31, rbit());
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // BYPASS: TDI 1,0,1,1 emerges one cycle late behind the captured 0.
        load_ir(4'b1111);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // EXTEST: Mode, ClockDR over capture + 34 shifts, TDO from chain.
        load_ir(4'b0000);
        scan_dr(34);
        load_ir(4'b0001);
        scan_dr(5);

        // IR load of IDCODE, then an unlisted code that acts as BYPASS.
        load_ir(4'b0010);
        load_ir(4'b0110);
        scan_dr(3);

        // IDCODE shift split by a pause.
        load_ir(4'b0010);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        repeat (10) tick(1'b0, rbit());
        tick(1'b1, rbit());
        tick(1'b0, rbit());
        tick(1'b0, rbit());
        tick(1'b1, rbit());
        tick(1'b0, rbit());
        repeat (22) tick(1'b0, rbit());
        tick(1'b1, rbit());
        tick(1'b1, rbit());
        tick(1'b0, rbit());

        // Reset in the middle of an EXTEST shift.
        load_ir(4'b0000);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        repeat (5) tick(1'b0, rbit());
        do_reset();
        tick(1'b0, 1'b0);

        // Random instruction loads and DR scans.
        repeat (40) begin
            goto_rti();
            load_ir(IR_W'($urandom_range(0, 15)));
            scan_dr(int'($urandom_range(1, 40)));
        end

        // Random TMS walk with occasional asynchronous resets.
        repeat (1500) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else tick(rtms(30), rbit());
        end

        goto_rti();
        repeat (3) @(negedge TCK);
        #3;
        chk("drain", 64'(exp_q.size() + tdo_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
